// File: rtl/scroll_seq_pkg.sv
// scroll_seq_pkg: shared constants, queue entry layout and sequencer states
package scroll_seq_pkg;
   localparam int LANE_COUNT = 8;
   localparam int LANE_WIDTH = 2;
   localparam int DVSR_WIDTH = 8;
   localparam int HOLD_WIDTH = 8;
   localparam int PAT_WIDTH = LANE_COUNT * LANE_WIDTH;
   localparam logic [13:0] REG_LANE = 14'd0;
   localparam logic [13:0] REG_DVSR = 14'd1;
   localparam logic [13:0] REG_BYPS = 14'd2;
   localparam logic [13:0] REG_DOWN = 14'd3;
   localparam logic [1:0] HOST_PUSH = 2'd0;
   localparam logic [1:0] HOST_DVSR = 2'd1;
   localparam logic [1:0] HOST_CTRL = 2'd2;
   localparam logic [1:0] HOST_CLR = 2'd3;
   localparam int CTRL_RUN = 0;
   localparam int CTRL_BYPS = 1;
   localparam int CTRL_DOWN = 2;
   localparam int CTRL_CLEAR = 4;
   localparam int ST_EMPTY = 8;
   localparam int ST_FULL = 9;
   localparam int ST_OVF = 10;
   localparam int ST_UNDR = 11;
   localparam int ST_RUN = 12;
   typedef struct packed {
      logic [HOLD_WIDTH-1:0] hold;
      logic [PAT_WIDTH-1:0] pattern;
   } entry_t;
   typedef enum logic [2:0] {IDLE, CFG_DVSR, CFG_BYPS, CFG_DOWN, RUN, LANE_WR, STOP} state_t;
   function automatic logic [7:0] at_least_one(input logic [7:0] v);
      return v == 8'd0 ? 8'd1 : v;
   endfunction
endpackage

// File: rtl/scroll_sequencer_if.sv
// scroll_sequencer_if: video-slot register bus shared by host and core sides
interface scroll_sequencer_if;
   logic cs;
   logic write;
   logic read;
   logic [13:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   modport master(output cs, write, read, addr, wr_data, input rd_data);
   modport slave(input cs, write, read, addr, wr_data, output rd_data);
endinterface

// File: rtl/scroll_seq_fifo.sv
// scroll_seq_fifo: pattern queue with show-ahead head, clear beats push and pop
module scroll_seq_fifo
   import scroll_seq_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push,
   input  logic pop,
   input  logic clear,
   input  entry_t din,
   output entry_t dout,
   output logic full,
   output logic empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   entry_t mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic do_push, do_pop;
   always_comb begin
      empty = count_q == '0;
      full = count_q == (AW+1)'(DEPTH);
      count = count_q;
      dout = mem_q[rd_ptr_q];
      do_pop = pop && !empty && !clear;
      // a full queue still accepts a push when the head leaves in the same cycle
      do_push = push && (!full || do_pop) && !clear;
      wr_ptr_d = clear ? '0 : wr_ptr_q + AW'(do_push);
      rd_ptr_d = clear ? '0 : rd_ptr_q + AW'(do_pop);
      count_d = clear ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: paces queued lane patterns to the scrolling core at the row rate
// and owns every core register write (config after reset or host change, lane, stop).
module scroll_sequencer
   import scroll_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input logic clk,
   input logic reset_n,
   input logic [10:0] x,
   input logic [10:0] y,
   scroll_sequencer_if.slave host,
   scroll_sequencer_if.master core
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state_q, state_d;
   logic run_q, run_d, byps_q, byps_d, down_q, down_d;
   logic ovf_q, ovf_d, undr_q, undr_d, cfg_q, cfg_d;
   logic tick_q, tick_d, blank_q, blank_d, fs_q, fs_d, m_cs_q, m_cs_d;
   logic [7:0] dvsr_q, dvsr_d, fcnt_q, fcnt_d, hold_q, hold_d;
   logic [PAT_WIDTH-1:0] lane_q, lane_d;
   logic [13:0] m_addr_q, m_addr_d;
   logic [31:0] m_data_q, m_data_d, status;
   logic hwr, push, ctrl_wr, dvsr_wr, flag_clr, clear, pop, undr_hit;
   logic frame_start, row_tick, tick, full, empty;
   logic [CW-1:0] count;
   entry_t head;
   logic unused_ok;
   assign unused_ok = &{1'b0, host.addr[13:2], host.wr_data[31:24], core.rd_data};
   scroll_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset_n(reset_n),
      .push(push),
      .pop(pop),
      .clear(clear),
      .din(entry_t'(host.wr_data[23:0])),
      .dout(head),
      .full(full),
      .empty(empty),
      .count(count)
   );
   always_comb begin
      hwr = host.cs && host.write;
      push = hwr && host.addr[1:0] == HOST_PUSH;
      dvsr_wr = hwr && host.addr[1:0] == HOST_DVSR;
      ctrl_wr = hwr && host.addr[1:0] == HOST_CTRL;
      flag_clr = hwr && host.addr[1:0] == HOST_CLR;
      clear = ctrl_wr && host.wr_data[CTRL_CLEAR];
      fs_d = x == '0 && y == '0;
      frame_start = fs_d && !fs_q;
      // >= rather than == so a shrinking divisor cannot strand the counter past its wrap
      row_tick = run_q && frame_start && fcnt_q >= at_least_one(dvsr_q) - 8'd1;
      fcnt_d = !run_q || row_tick ? '0 : frame_start ? fcnt_q + 8'd1 : fcnt_q;
      run_d = ctrl_wr ? host.wr_data[CTRL_RUN] : run_q;
      byps_d = ctrl_wr ? host.wr_data[CTRL_BYPS] : byps_q;
      down_d = ctrl_wr ? host.wr_data[CTRL_DOWN] : down_q;
      dvsr_d = dvsr_wr ? host.wr_data[7:0] : dvsr_q;
      cfg_d = dvsr_wr || (ctrl_wr && (byps_d != byps_q || down_d != down_q))
              || (cfg_q && state_q != CFG_DOWN);
      ovf_d = !flag_clr && (ovf_q || (push && !clear && full && !pop));
      undr_d = !flag_clr && (undr_q || undr_hit);
      status = 32'(count);
      status[ST_EMPTY] = empty;
      status[ST_FULL] = full;
      status[ST_OVF] = ovf_q;
      status[ST_UNDR] = undr_q;
      status[ST_RUN] = run_q;
      host.rd_data = host.cs && host.read ? status : '0;
   end
   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      lane_d = lane_q;
      blank_d = blank_q;
      pop = 1'b0;
      undr_hit = 1'b0;
      tick = row_tick || tick_q;
      tick_d = tick;
      m_cs_d = 1'b0;
      m_addr_d = '0;
      m_data_d = '0;
      case (state_q)
         IDLE: state_d = cfg_q ? CFG_DVSR : run_q ? RUN : IDLE;
         CFG_DVSR: begin
            m_cs_d = 1'b1;
            m_addr_d = REG_DVSR;
            m_data_d = 32'(dvsr_q);
            state_d = CFG_BYPS;
         end
         CFG_BYPS: begin
            m_cs_d = 1'b1;
            m_addr_d = REG_BYPS;
            m_data_d = 32'(byps_q);
            state_d = CFG_DOWN;
         end
         CFG_DOWN: begin
            m_cs_d = 1'b1;
            m_addr_d = REG_DOWN;
            m_data_d = 32'(down_q);
            state_d = run_q ? RUN : IDLE;
         end
         RUN: begin
            if (!run_q) begin
               tick_d = 1'b0;
               state_d = STOP;
            end else if (tick) begin
               tick_d = 1'b0;
               if (hold_q > 8'd1) begin
                  hold_d = hold_q - 8'd1;
               end else if (!empty) begin
                  pop = 1'b1;
                  hold_d = at_least_one(head.hold);
                  lane_d = head.pattern;
                  blank_d = 1'b0;
                  state_d = LANE_WR;
               end else begin
                  // blank the core once per starvation episode, not on every tick
                  undr_hit = 1'b1;
                  hold_d = '0;
                  lane_d = '0;
                  blank_d = 1'b1;
                  state_d = blank_q ? RUN : LANE_WR;
               end
            end else if (cfg_q) begin
               state_d = CFG_DVSR;
            end
         end
         LANE_WR: begin
            m_cs_d = 1'b1;
            m_addr_d = REG_LANE;
            m_data_d = 32'(lane_q);
            state_d = RUN;
         end
         STOP: begin
            m_cs_d = 1'b1;
            m_addr_d = REG_LANE;
            tick_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clear) hold_d = '0;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cfg_q <= 1'b1;
         run_q <= 1'b0;
         byps_q <= 1'b0;
         down_q <= 1'b0;
         ovf_q <= 1'b0;
         undr_q <= 1'b0;
         tick_q <= 1'b0;
         blank_q <= 1'b0;
         fs_q <= 1'b0;
         dvsr_q <= '0;
         fcnt_q <= '0;
         hold_q <= '0;
         lane_q <= '0;
         m_cs_q <= 1'b0;
         m_addr_q <= '0;
         m_data_q <= '0;
      end else begin
         state_q <= state_d;
         cfg_q <= cfg_d;
         run_q <= run_d;
         byps_q <= byps_d;
         down_q <= down_d;
         ovf_q <= ovf_d;
         undr_q <= undr_d;
         tick_q <= tick_d;
         blank_q <= blank_d;
         fs_q <= fs_d;
         dvsr_q <= dvsr_d;
         fcnt_q <= fcnt_d;
         hold_q <= hold_d;
         lane_q <= lane_d;
         m_cs_q <= m_cs_d;
         m_addr_q <= m_addr_d;
         m_data_q <= m_data_d;
      end
   end
   assign core.cs = m_cs_q;
   assign core.write = m_cs_q;
   assign core.read = 1'b0;
   assign core.addr = m_addr_q;
   assign core.wr_data = m_data_q;
endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: directed plus random host traffic against a transaction-level
// model of the queue, row pacing and core write stream.
module tb_scroll_sequencer;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [10:0] x = 11'd5;
   logic [10:0] y = 11'd5;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   scroll_sequencer_if h();
   scroll_sequencer_if c();
   scroll_sequencer dut (.clk(clk), .reset_n(reset_n), .x(x), .y(y), .host(h), .core(c));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   logic [46:0] obs_q[$];
   logic [46:0] exp_q[$];
   int obs_t[$];
   always @(negedge clk) begin
      if (c.cs === 1'b1) begin
         obs_q.push_back({c.write, c.addr, c.wr_data});
         obs_t.push_back(cyc);
      end
   end
   logic [23:0] mq[$];
   int mhold = 0, mfcnt = 0, mdvsr = 0;
   bit mrun = 0, mbyp = 0, mdown = 0, mover = 0, munder = 0, mblank = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      h.cs = 1; h.write = 1; h.addr = {12'd0, a}; h.wr_data = d;
      @(negedge clk);
      h.cs = 0; h.write = 0;
   endtask
   task automatic exp_cfg;
      exp_q.push_back({1'b1, 14'd1, 32'(mdvsr)});
      exp_q.push_back({1'b1, 14'd2, 31'd0, mbyp});
      exp_q.push_back({1'b1, 14'd3, 31'd0, mdown});
   endtask
   task automatic model_push(input logic [23:0] e);
      if (mq.size() < 16) mq.push_back(e);
      else mover = 1;
   endtask
   task automatic model_tick;
      logic [23:0] e;
      if (mhold > 1) mhold--;
      else if (mq.size() > 0) begin
         e = mq.pop_front();
         mhold = e[23:16] == 0 ? 1 : int'(e[23:16]);
         exp_q.push_back({1'b1, 14'd0, 16'd0, e[15:0]});
         mblank = 0;
      end else begin
         munder = 1;
         mhold = 0;
         if (!mblank) exp_q.push_back({1'b1, 14'd0, 32'd0});
         mblank = 1;
      end
   endtask
   task automatic model_frame;
      if (mrun) begin
         if (mfcnt >= (mdvsr == 0 ? 1 : mdvsr) - 1) begin
            mfcnt = 0;
            model_tick();
         end else mfcnt++;
      end
   endtask
   task automatic do_push(input logic [23:0] e);
      bus_wr(2'd0, {8'd0, e});
      model_push(e);
      idle(2);
   endtask
   task automatic do_dvsr(input int d);
      bus_wr(2'd1, 32'(d));
      mdvsr = d;
      exp_cfg();
      idle(8);
   endtask
   task automatic do_ctrl(input bit run, input bit byp, input bit down, input bit clr);
      bit chg;
      bus_wr(2'd2, {27'd0, clr, 1'b0, down, byp, run});
      chg = byp != mbyp || down != mdown;
      if (mrun && !run) exp_q.push_back({1'b1, 14'd0, 32'd0});
      if (!run) mfcnt = 0;
      mrun = run; mbyp = byp; mdown = down;
      if (chg) exp_cfg();
      if (clr) begin
         mq.delete();
         mhold = 0;
      end
      idle(8);
   endtask
   task automatic clr_flags;
      bus_wr(2'd3, 32'd0);
      mover = 0; munder = 0;
      idle(2);
   endtask
   task automatic frame(input bit with_push, input logic [23:0] e);
      @(negedge clk);
      x = 0; y = 0;
      if (with_push) begin
         h.cs = 1; h.write = 1; h.addr = 14'd0; h.wr_data = {8'd0, e};
      end
      @(negedge clk);
      x = 11'd1; h.cs = 0; h.write = 0;
      model_frame();
      if (with_push) model_push(e);
      idle(8);
   endtask
   task automatic check_status(input string tag);
      logic [31:0] s;
      s = 32'(mq.size());
      s[8] = mq.size() == 0;
      s[9] = mq.size() == 16;
      s[10] = mover;
      s[11] = munder;
      s[12] = mrun;
      @(negedge clk);
      h.cs = 1; h.read = 1;
      #1 check(tag, h.rd_data, s);
      h.cs = 0; h.read = 0;
   endtask
   task automatic cmp_writes(input string tag);
      idle(2);
      check({tag, "_n"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
      obs_q.delete(); exp_q.delete(); obs_t.delete();
   endtask
   task automatic midcfg;
      bus_wr(2'd2, 32'h5);
      mdown = 1;
      exp_cfg();
      @(negedge clk);
      x = 0; y = 0;
      @(negedge clk);
      x = 11'd1;
      model_frame();
      idle(10);
      cmp_writes("midcfg");
   endtask

   initial begin
      bit seen;
      int op;
      h.cs = 0; h.write = 0; h.read = 0; h.addr = '0; h.wr_data = '0; c.rd_data = '0;
      #12;
      check("rst_cs", c.cs, 0);
      check("rst_addr", c.addr, 0);
      check("rst_data", c.wr_data, 0);
      check("rst_rd", h.rd_data, 0);
      @(negedge clk);
      reset_n = 1;
      exp_cfg();
      idle(8);
      check("cfg_gap", obs_t.size() == 3 ? obs_t[2] - obs_t[0] : 0, 2);
      cmp_writes("rst_cfg");
      check_status("st_reset");

      do_dvsr(2);
      do_push(24'h031B1B);
      do_push(24'h0100E4);
      do_ctrl(1, 0, 0, 0);
      cmp_writes("setup");
      for (int i = 0; i < 14; i++) begin
         frame(0, 24'd0);
         cmp_writes("frame");
      end
      check_status("st_undr");
      clr_flags();
      check_status("st_undrclr");

      do_ctrl(0, 0, 0, 0);
      for (int i = 0; i < 17; i++) do_push({8'd0, 16'($urandom)});
      cmp_writes("stop");
      check_status("st_full");
      clr_flags();
      do_dvsr(1);
      do_ctrl(1, 0, 0, 0);
      cmp_writes("restart");
      frame(1, {8'd0, 16'($urandom)});
      cmp_writes("pushpop");
      check_status("st_pushpop");

      midcfg();
      do_ctrl(1, 0, 1, 1);
      check_status("st_clear");
      frame(1, 24'h00BEEF);
      cmp_writes("push_tick");
      check_status("st_push_tick");

      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 9);
         if (op < 4) do_push({8'($urandom_range(0, 3)), 16'($urandom)});
         else if (op < 8) frame(1'($urandom_range(0, 1)), {8'($urandom_range(0, 3)), 16'($urandom)});
         else if (op == 8) do_dvsr($urandom_range(0, 3));
         else check_status("st_rand");
         cmp_writes("rand");
      end

      do_ctrl(1, 0, 1, 1);
      do_dvsr(1);
      do_push(24'h00ABCD);
      cmp_writes("pre_lane");
      @(negedge clk);
      x = 0; y = 0;
      @(negedge clk);
      x = 11'd1;
      model_frame();
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = c.cs;
      end
      check("lane_seen", seen, 1);
      #2 reset_n = 0;
      #1 check("cs_async", c.cs, 0);
      check("addr_async", c.addr, 0);
      check("data_async", c.wr_data, 0);
      check("rd_async", h.rd_data, 0);
      mq.delete();
      mhold = 0; mfcnt = 0; mdvsr = 0;
      mrun = 0; mbyp = 0; mdown = 0; mover = 0; munder = 0; mblank = 0;
      cmp_writes("lane_rst");
      @(negedge clk);
      reset_n = 1;
      exp_cfg();
      idle(8);
      cmp_writes("post_rst");
      check_status("st_post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/scroll_sequencer.md
Name: scroll_sequencer

Overview:
- Host-programmable scheduler that drives the scrolling core's video-slot write port (lane word, divisor, bypass, direction registers) as a bus master.
- The CPU queues lane patterns with hold counts into a FIFO. The sequencer paces them out at the core's row rate, derived from the frame counter.
- It sits between the CPU video slot and the scrolling core, and owns all core register writes.

Parameters:
- FIFO_DEPTH, 16, entries in pattern queue (power of two)
- LANE_COUNT, 8, lanes per pattern
- LANE_WIDTH, 2, bits per lane code
- DVSR_WIDTH, 8, frames per row divisor width
- HOLD_WIDTH, 8, rows-per-entry counter width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- x  in  11  frame counter column
- y  in  11  frame counter row
- cs  in  1  host slot select
- write  in  1  host write strobe
- read  in  1  host read strobe (status has no read side effects)
- addr  in  14  host register address, only [1:0] decoded
- wr_data  in  32  host write data
- rd_data  out  32  host read data, combinational from registers
- m_cs  out  1  core slot select, registered
- m_write  out  1  core write strobe, registered, equals m_cs
- m_addr  out  14  core register address: 0 lane, 1 dvsr, 2 bypass, 3 down
- m_wr_data  out  32  core write data

Behaviour:
- Reset (reset_n low, async):
  - m_cs, m_write, m_addr and m_wr_data go to 0; rd_data reads 0.
  - FIFO empty; hold counter, frame counter, ctrl, dvsr and sticky flags all 0.
  - FSM enters IDLE with cfg_pending=1, so the core is configured right after reset.
- Host writes (cs&write):
  - addr 0, push: entry = {hold=wr_data[23:16], pattern=wr_data[15:0]}. If the FIFO is full, the entry is dropped and overflow (sticky) is set.
  - addr 1: dvsr=wr_data[7:0]; sets cfg_pending.
  - addr 2, ctrl: bit0 run, bit1 bypass, bit2 down, bit4 clear (self-clearing). A change to bypass or down sets cfg_pending.
  - addr 3: clears overflow and underrun.
- Host read (any addr) returns status:
  - [4:0] fifo count
  - bit8 empty, bit9 full, bit10 overflow, bit11 underrun, bit12 running
- Row timing:
  - frame_start is a one-cycle pulse on the rising edge of (x==0 && y==0).
  - The frame counter counts frame_start pulses. row_tick pulses when it reaches max(dvsr,1)-1, then the counter wraps to 0.
  - The frame counter is held at 0 while not running.
- FSM states and transitions:
  - IDLE: on cfg_pending -> CFG_DVSR. Else on run=1 -> RUN.
  - CFG_DVSR: one master write, addr1, data dvsr -> CFG_BYPS.
  - CFG_BYPS: one master write, addr2, data bypass -> CFG_DOWN.
  - CFG_DOWN: one master write, addr3, data down; clears cfg_pending -> back to IDLE or RUN, per run.
  - RUN, on row_tick:
    - hold>1: decrement hold, no write.
    - Otherwise, FIFO non-empty: pop, load hold=max(entry.hold,1) -> LANE_WR with the entry pattern.
    - Otherwise, FIFO empty: set underrun, hold=0 -> LANE_WR with 0 (blank), written once per underrun episode only.
  - RUN, run=0 -> STOP.
  - RUN, cfg_pending with no row_tick this cycle -> CFG_DVSR.
  - LANE_WR: one master write, addr0, data zero-extended pattern -> RUN.
  - STOP: one master write, addr0, data 0 -> IDLE.
- Priority: a row_tick arriving during CFG_* is latched (tick_pending) and serviced on return to RUN. It is never lost.
- Master write: m_cs=m_write=1 for exactly one cycle per write state. All master outputs are 0 otherwise.
- FIFO boundaries:
  - Simultaneous push and pop: both occur, count unchanged, including when full.
  - Push to empty plus row_tick in the same cycle: the entry is not visible until the next cycle, so the tick underruns.
  - clear: FIFO emptied and hold=0. Clear wins over a same-cycle push.

Decomposition:
- Package scroll_seq_pkg:
  - register address constants (REG_LANE/DVSR/BYPS/DOWN, HOST_PUSH/DVSR/CTRL/CLR)
  - ctrl bit indices
  - status bit indices
  - packed entry struct {hold, pattern}
  - FSM state enum
- Sub-module scroll_seq_fifo: synchronous FIFO with push, pop, clear, full, empty and count outputs, and first-word data visible at the output.

Test Plan:
- Reset release, run=0 -> exactly three master writes (addr1 data 0, addr2 data 0, addr3 data 0) on consecutive cycles, then idle.
- dvsr=2; push {hold=3, pattern 0x1B1B} and {hold=1, pattern 0x00E4}; run=1 -> write addr0 0x1B1B on the first row_tick (2nd frame), then addr0 0x00E4 exactly 3 row_ticks (6 frames) later.
- FIFO drains -> single addr0 0 write, status bit11=1. Further ticks produce no writes. Write addr3 -> bit11=0.
- Push 17 entries with run=0 -> count=16, full=1, overflow=1. A simultaneous push and pop when full keeps count=16 with no overflow.
- Write ctrl bit2 (down) while running, with a row_tick arriving mid-config -> addr1, addr2, addr3(data 1) sequence, then the pending lane write still issues.
- Assert reset_n low during LANE_WR -> m_cs drops to 0 asynchronously; after release, the post-reset config sequence repeats.
